// File: rtl/matrix_wb_framebuffer.sv
// matrix_wb_framebuffer: double-buffered LED frame store with a pipelined Wishbone port and a scanner read port
//  clk, reset_n                  clock and asynchronous active-low reset
//  i_wb_cyc/stb/we/addr/sel/wdata Wishbone request into the back bank
//  o_wb_ack/stall/rdata          Wishbone response (stall while a swap is armed)
//  i_frame_sync                  scanner frame boundary pulse, takes an armed swap
//  i_rd_row, o_rd_data           scanner row select and registered front-bank row
//  o_front, o_swap_pending, o_swap_count  bank status
module matrix_wb_framebuffer #(
   parameter int WB_DATA_WIDTH = 32,
   parameter int REG_COUNT     = 8,
   parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
   parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_wb_cyc,
   input  logic                     i_wb_stb,
   input  logic                     i_wb_we,
   input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
   input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
   input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
   output logic                     o_wb_ack,
   output logic                     o_wb_stall,
   output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
   input  logic                     i_frame_sync,
   input  logic [WB_ADDR_WIDTH-1:0] i_rd_row,
   output logic [WB_DATA_WIDTH-1:0] o_rd_data,
   output logic                     o_front,
   output logic                     o_swap_pending,
   output logic [3:0]               o_swap_count
);
   logic [WB_DATA_WIDTH-1:0] bank [2][REG_COUNT];
   logic [WB_DATA_WIDTH-1:0] mask, row_old, row_new;
   logic front, back, front_nx, ack_q, accept, swap, arm;
   genvar k;
   generate
      for (k = 0; k < WB_SEL_WIDTH; k++) begin : g_lane
         assign mask[k*8 +: 8] = {8{i_wb_sel[k]}};
      end
   endgenerate
   assign o_wb_stall = o_swap_pending;
   assign accept     = i_wb_cyc & i_wb_stb & ~o_wb_stall;
   assign swap       = i_frame_sync & o_swap_pending;
   assign arm        = accept & i_wb_we & (i_wb_addr == WB_ADDR_WIDTH'(REG_COUNT - 1));
   assign back       = ~front;
   // scanner samples the bank that is front after this edge, so a swap shows up without an extra cycle
   assign front_nx   = front ^ swap;
   assign o_front    = front;
   assign o_wb_ack   = ack_q & i_wb_cyc;
   assign row_old    = bank[back][i_wb_addr];
   assign row_new    = (row_old & ~mask) | (i_wb_wdata & mask);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank           <= '{default: '0};
         front          <= 1'b0;
         ack_q          <= 1'b0;
         o_wb_rdata     <= '0;
         o_rd_data      <= '0;
         o_swap_pending <= 1'b0;
         o_swap_count   <= 4'd0;
      end else begin
         ack_q <= accept;
         if (accept & i_wb_we) bank[back][i_wb_addr] <= row_new;
         if (accept & ~i_wb_we) o_wb_rdata <= row_old;
         // arming only happens while not pending, so it never coincides with a swap
         if (arm) o_swap_pending <= 1'b1;
         else if (swap) o_swap_pending <= 1'b0;
         if (swap) begin
            front        <= ~front;
            o_swap_count <= o_swap_count + 4'd1;
         end
         o_rd_data <= bank[front_nx][i_rd_row];
      end
   end
endmodule

// File: tb/tb_matrix_wb_framebuffer.sv
// tb_matrix_wb_framebuffer: randomized and directed checks of matrix_wb_framebuffer against a frame-level model
module tb_matrix_wb_framebuffer;
   localparam int W = 32, N = 8, AW = 3, SW = 4;
   logic clk = 1'b0, reset_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0, sync = 1'b0;
   logic [AW-1:0] addr = '0, rd_row = '0;
   logic [SW-1:0] sel = '0;
   logic [W-1:0] wdata = '0;
   logic ack, stall, front, pend;
   logic [W-1:0] rdata, rd_data;
   logic [3:0] cnt;
   int vectors = 0, miscompares = 0;
   logic [W-1:0] m_bank [2][N];
   logic m_front, m_pend, m_ackq;
   logic [3:0] m_cnt;
   logic [W-1:0] m_rdata, m_rd;

   matrix_wb_framebuffer dut (
      .clk(clk), .reset_n(reset_n),
      .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
      .i_wb_sel(sel), .i_wb_wdata(wdata),
      .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_rdata(rdata),
      .i_frame_sync(sync), .i_rd_row(rd_row), .o_rd_data(rd_data),
      .o_front(front), .o_swap_pending(pend), .o_swap_count(cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic model_reset();
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < N; r++) m_bank[b][r] = '0;
      m_front = 0; m_pend = 0; m_ackq = 0; m_cnt = 0; m_rdata = '0; m_rd = '0;
   endtask

   task automatic idle();
      cyc = 1; stb = 0; we = 0; sync = 0; sel = '0; wdata = '0; addr = '0;
   endtask

   // one clock: the model applies the frame rules for the inputs now on the bus, then the DUT edge passes
   task automatic tick();
      bit acc, sw;
      int b;
      acc = cyc && stb && !m_pend;
      sw = sync && m_pend;
      b = m_front ? 0 : 1;
      if (acc && !we) m_rdata = m_bank[b][addr];
      if (acc && we) begin
         for (int k = 0; k < SW; k++)
            if (sel[k]) m_bank[b][addr][k*8 +: 8] = wdata[k*8 +: 8];
         if (int'(addr) == N - 1) m_pend = 1;
      end
      if (sw) begin
         m_front = !m_front;
         m_pend = 0;
         m_cnt = m_cnt + 4'd1;
      end
      m_rd = m_bank[m_front][rd_row];
      m_ackq = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 0;
      #1;
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack got %b want 0", ack); end
      vectors++; if (rdata !== '0) begin miscompares++; $display("FAIL reset_rdata got %h want 0", rdata); end
      vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
      vectors++; if ({front, pend, cnt} !== 6'd0) begin miscompares++; $display("FAIL reset_status got %b want 0", {front, pend, cnt}); end
      model_reset();
      idle();
      @(negedge clk);
      reset_n = 1;
      #1;
      vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
   endtask

   task automatic test_fill();
      idle(); stb = 1; we = 1; sel = 4'hF;
      #1;
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL fill_early_ack got %b want 0", ack); end
      for (int r = 0; r < N; r++) begin
         addr = AW'(r); wdata = 32'h00500500 + r;
         tick();
         vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL fill_ack row %0d got %b want 1", r, ack); end
      end
      stb = 0; rd_row = 3'd2;
      tick();
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL fill_idle_ack got %b want 0", ack); end
      vectors++; if (pend !== 1'b1) begin miscompares++; $display("FAIL fill_pending got %b want 1", pend); end
      vectors++; if (front !== 1'b0) begin miscompares++; $display("FAIL fill_front got %b want 0", front); end
      vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL fill_rd_data got %h want 0", rd_data); end
   endtask

   task automatic test_swap();
      rd_row = 3'd0; sync = 1;
      tick();
      sync = 0;
      vectors++; if ({front, pend, cnt} !== {1'b1, 1'b0, 4'd1}) begin miscompares++; $display("FAIL swap_status got %b want %b", {front, pend, cnt}, {1'b1, 1'b0, 4'd1}); end
      vectors++; if (rd_data !== 32'h00500500) begin miscompares++; $display("FAIL swap_rd_immediate got %h want 00500500", rd_data); end
      rd_row = 3'd2;
      tick();
      vectors++; if (rd_data !== 32'h00500502) begin miscompares++; $display("FAIL swap_rd_row2 got %h want 00500502", rd_data); end
   endtask

   task automatic test_stall();
      logic [W-1:0] fill3;
      idle(); stb = 1; we = 1; sel = 4'hF;
      fill3 = '0;
      for (int r = 0; r < N; r++) begin
         addr = AW'(r); wdata = $urandom;
         if (r == 3) fill3 = wdata;
         tick();
      end
      addr = 3'd3; wdata = ~fill3;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++; if (stall !== 1'b1 || ack !== 1'b0) begin miscompares++; $display("FAIL stall_hold cyc %0d got stall=%b ack=%b want stall=1 ack=0", i, stall, ack); end
      end
      sync = 1;
      tick();
      sync = 0;
      vectors++; if (stall !== 1'b0 || ack !== 1'b0) begin miscompares++; $display("FAIL stall_release got stall=%b ack=%b want 0 0", stall, ack); end
      tick();
      vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL stall_held_accept got ack=%b want 1", ack); end
      stb = 0; rd_row = 3'd3;
      tick();
      vectors++; if (rd_data !== fill3) begin miscompares++; $display("FAIL stall_unchanged got %h want %h", rd_data, fill3); end
   endtask

   task automatic test_byte_lanes();
      idle(); stb = 1; we = 1; addr = 3'd1;
      sel = 4'hF; wdata = 32'h54455445;
      tick();
      sel = 4'b0010; wdata = 32'hFFFFFFFF;
      tick();
      sel = 4'b0000; wdata = 32'h12345678;
      tick();
      vectors++; if (ack !== 1'b1) begin miscompares++; $display("FAIL lanes_sel0_ack got %b want 1", ack); end
      we = 0;
      tick();
      stb = 0;
      vectors++; if (ack !== 1'b1 || rdata !== 32'h5445FF45) begin miscompares++; $display("FAIL lanes_read got ack=%b data=%h want 1 5445FF45", ack, rdata); end
      tick();
      vectors++; if (rdata !== 32'h5445FF45) begin miscompares++; $display("FAIL lanes_rdata_hold got %h want 5445FF45", rdata); end
   endtask

   task automatic test_sync_arm();
      logic [3:0] c0;
      c0 = m_cnt;
      idle(); stb = 1; we = 1; addr = 3'd7; sel = 4'($urandom); wdata = $urandom; sync = 1;
      tick();
      stb = 0; sync = 0;
      vectors++; if (pend !== 1'b1 || front !== m_front || cnt !== c0) begin miscompares++; $display("FAIL arm_sync_same got pend=%b front=%b cnt=%0d want 1 %b %0d", pend, front, cnt, m_front, c0); end
      sync = 1;
      tick();
      sync = 0;
      vectors++; if (pend !== 1'b0 || cnt !== c0 + 4'd1 || front !== m_front) begin miscompares++; $display("FAIL arm_next_sync got pend=%b cnt=%0d front=%b want 0 %0d %b", pend, cnt, front, c0 + 4'd1, m_front); end
   endtask

   task automatic test_abort();
      logic [W-1:0] d;
      d = $urandom;
      idle(); stb = 1; we = 1; addr = 3'd4; sel = 4'hF; wdata = d;
      tick();
      stb = 0; cyc = 0;
      #1;
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL abort_ack got %b want 0", ack); end
      tick();
      cyc = 1; stb = 1; we = 0;
      tick();
      stb = 0;
      vectors++; if (ack !== 1'b1 || rdata !== d) begin miscompares++; $display("FAIL abort_kept got ack=%b data=%h want 1 %h", ack, rdata, d); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cyc = ($urandom_range(0, 9) != 0);
         stb = 1'($urandom);
         we = 1'($urandom);
         addr = AW'($urandom_range(0, N - 1));
         sel = SW'($urandom);
         wdata = $urandom;
         sync = ($urandom_range(0, 5) == 0);
         rd_row = AW'($urandom_range(0, N - 1));
         tick();
         vectors++; if (ack !== (m_ackq && cyc)) begin miscompares++; $display("FAIL rnd_ack %0d got %b want %b", i, ack, m_ackq && cyc); end
         vectors++; if (stall !== m_pend || pend !== m_pend) begin miscompares++; $display("FAIL rnd_pend %0d got stall=%b pend=%b want %b", i, stall, pend, m_pend); end
         vectors++; if (rdata !== m_rdata) begin miscompares++; $display("FAIL rnd_rdata %0d got %h want %h", i, rdata, m_rdata); end
         vectors++; if (rd_data !== m_rd) begin miscompares++; $display("FAIL rnd_rd_data %0d got %h want %h", i, rd_data, m_rd); end
         vectors++; if (front !== m_front || cnt !== m_cnt) begin miscompares++; $display("FAIL rnd_bank %0d got front=%b cnt=%0d want %b %0d", i, front, cnt, m_front, m_cnt); end
      end
      sync = 0;
   endtask

   task automatic test_wrap();
      logic [3:0] c0;
      int zero_seen;
      idle(); sync = 1;
      tick();
      sync = 0;
      c0 = m_cnt;
      zero_seen = 0;
      for (int f = 0; f < 16; f++) begin
         stb = 1; we = 1; sel = 4'hF;
         for (int r = 0; r < N; r++) begin
            addr = AW'(r); wdata = $urandom;
            tick();
         end
         stb = 0; sync = 1;
         tick();
         sync = 0;
         vectors++; if (cnt !== 4'((int'(c0) + f + 1) % 16)) begin miscompares++; $display("FAIL wrap_count frame %0d got %0d want %0d", f, cnt, (int'(c0) + f + 1) % 16); end
         if ((int'(c0) + f + 1) % 16 == 0) zero_seen = (cnt === 4'd0) ? 1 : 0;
      end
      vectors++; if (zero_seen !== 1) begin miscompares++; $display("FAIL wrap_zero got %0d want 1", zero_seen); end
   endtask

   task automatic test_reset_mid();
      idle(); stb = 1; we = 1; sel = 4'hF;
      for (int r = 0; r < 3; r++) begin
         addr = AW'(r); wdata = $urandom | 32'h1;
         tick();
      end
      #2;
      reset_n = 0;
      #1;
      vectors++; if ({ack, stall, front, pend, cnt} !== 8'd0) begin miscompares++; $display("FAIL rstmid_status got %b want 0", {ack, stall, front, pend, cnt}); end
      vectors++; if (rdata !== '0 || rd_data !== '0) begin miscompares++; $display("FAIL rstmid_data got %h %h want 0 0", rdata, rd_data); end
      model_reset();
      idle();
      @(negedge clk);
      reset_n = 1;
      stb = 1; we = 0; addr = 3'd1; rd_row = 3'd1;
      tick();
      stb = 0;
      vectors++; if (ack !== 1'b1 || rdata !== '0) begin miscompares++; $display("FAIL rstmid_cleared got ack=%b data=%h want 1 0", ack, rdata); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_fill();
      test_swap();
      test_stall();
      test_byte_lanes();
      test_sync_arm();
      test_abort();
      test_random();
      test_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
